// File: rtl/fall_engine.sv
// -----------------------------------------------------------------------------
// fall_engine
//   Falling-character game engine. SLOTS independent lanes each hold one ASCII
//   character with a y position and a fall speed. Spawns from the generator
//   are accepted into free lanes, frame ticks move characters down, keypresses
//   remove the lowest matching character, and misses cost lives. The game
//   runs an IDLE / PLAY / PAUSE / OVER flow and offers a registered per-lane
//   read port to the renderer.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, pause_tgl                 1-cycle control pulses
//   frame_tick                       1-cycle movement step pulse
//   key_valid, key_ascii             1-cycle keypress with its ASCII code
//   spawn_valid/slot/ascii/speed     spawn offer from the generator
//   spawn_ready                      spawn accepted when valid && ready
//   rd_slot -> rd_active/ascii/y     registered lane read (1-cycle latency)
//   state                            0 IDLE, 1 PLAY, 2 OVER, 3 PAUSE
//   score, lives                     game counters
//   gameover                         1-cycle pulse on PLAY->OVER
//
// Handshake: spawn_valid may be held for any number of cycles; a spawn is
// taken on every rising edge where spawn_valid && spawn_ready are both high.
// spawn_ready is combinational from state, spawn_slot and lane occupancy.
// -----------------------------------------------------------------------------
module fall_engine #(
   parameter int SLOTS       = 8,
   parameter int SLOT_W      = 3,
   parameter int Y_W         = 10,
   parameter int SPEED_W     = 3,
   parameter int LOWER_BOUND = 480,
   parameter int SCORE_W     = 8,
   parameter int MAX_LIVES   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pause_tgl,
   input  logic               frame_tick,
   input  logic               key_valid,
   input  logic [7:0]         key_ascii,
   input  logic               spawn_valid,
   input  logic [SLOT_W-1:0]  spawn_slot,
   input  logic [7:0]         spawn_ascii,
   input  logic [SPEED_W-1:0] spawn_speed,
   output logic               spawn_ready,
   input  logic [SLOT_W-1:0]  rd_slot,
   output logic               rd_active,
   output logic [7:0]         rd_ascii,
   output logic [Y_W-1:0]     rd_y,
   output logic [1:0]         state,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic               gameover
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_OVER  = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [SLOTS-1:0]     active_q, active_d;
   logic [Y_W-1:0]       y_q     [SLOTS];
   logic [Y_W-1:0]       y_d     [SLOTS];
   logic [7:0]           ascii_q [SLOTS];
   logic [7:0]           ascii_d [SLOTS];
   logic [SPEED_W-1:0]   speed_q [SLOTS];
   logic [SPEED_W-1:0]   speed_d [SLOTS];
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [2:0]           lives_q, lives_d;
   logic                 gameover_q, gameover_d;
   logic                 rd_active_q, rd_active_d;
   logic [7:0]           rd_ascii_q, rd_ascii_d;
   logic [Y_W-1:0]       rd_y_q, rd_y_d;

   // Per-lane movement result for a tick, computed from pre-tick positions.
   logic [Y_W:0]         y_sum  [SLOTS];
   logic [Y_W-1:0]       y_next [SLOTS];
   logic [SLOTS-1:0]     miss;

   // Key match: lowest character on screen (largest y), lowest index on a tie.
   logic                 match_found;
   logic [SLOT_W-1:0]    match_idx;
   logic [Y_W-1:0]       match_y;
   logic                 key_hit;

   logic                 spawn_slot_ok;
   logic                 spawn_sel_active;
   logic                 spawn_fire;
   int unsigned          miss_cnt;

   // ---------------------------------------------------------------------------
   // Spawn handshake
   // ---------------------------------------------------------------------------
   always_comb begin
      spawn_slot_ok    = 1'b0;
      spawn_sel_active = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (spawn_slot == SLOT_W'(i)) begin
            spawn_slot_ok    = 1'b1;
            spawn_sel_active = active_q[i];
         end
      end
   end

   assign spawn_ready = (state_q == S_PLAY) && spawn_slot_ok && !spawn_sel_active;
   assign spawn_fire  = spawn_valid && spawn_ready;

   // ---------------------------------------------------------------------------
   // Key match search
   // ---------------------------------------------------------------------------
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      match_y     = '0;
      for (int i = 0; i < SLOTS; i++) begin
         // Strict '>' keeps the earlier (lower) index when positions tie.
         if (active_q[i] && (ascii_q[i] == key_ascii) && (!match_found || (y_q[i] > match_y))) begin
            match_found = 1'b1;
            match_idx   = SLOT_W'(i);
            match_y     = y_q[i];
         end
      end
   end

   assign key_hit = (state_q == S_PLAY) && key_valid && match_found;

   // ---------------------------------------------------------------------------
   // Movement: saturating add, then miss test against the lower bound
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         y_sum[i]  = {1'b0, y_q[i]} + (Y_W + 1)'(speed_q[i]);
         y_next[i] = y_sum[i][Y_W] ? {Y_W{1'b1}} : y_sum[i][Y_W-1:0];
         miss[i]   = (32'(y_next[i]) >= LOWER_BOUND);
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      y_d        = y_q;
      ascii_d    = ascii_q;
      speed_d    = speed_q;
      score_d    = score_q;
      lives_d    = lives_q;
      gameover_d = 1'b0;
      miss_cnt   = 0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_PLAY;
               active_d = '0;
               for (int i = 0; i < SLOTS; i++) begin
                  y_d[i]     = '0;
                  ascii_d[i] = '0;
                  speed_d[i] = '0;
               end
               score_d = '0;
               lives_d = 3'(MAX_LIVES);
            end
         end

         S_PLAY: begin
            if (key_hit && (score_q != {SCORE_W{1'b1}})) begin
               score_d = score_q + 1'b1;
            end
            for (int i = 0; i < SLOTS; i++) begin
               if (key_hit && (match_idx == SLOT_W'(i))) begin
                  // The keyed lane is removed before the tick can move or miss it.
                  active_d[i] = 1'b0;
               end else if (frame_tick && active_q[i]) begin
                  if (miss[i]) begin
                     active_d[i] = 1'b0;
                     miss_cnt    = miss_cnt + 1;
                  end else begin
                     y_d[i] = y_next[i];
                  end
               end
               // A spawn only targets a free lane, so it never overlaps the cases above.
               if (spawn_fire && (spawn_slot == SLOT_W'(i))) begin
                  active_d[i] = 1'b1;
                  y_d[i]      = '0;
                  ascii_d[i]  = spawn_ascii;
                  speed_d[i]  = spawn_speed;
               end
            end
            if (frame_tick) begin
               lives_d = (miss_cnt >= 32'(lives_q)) ? 3'd0 : (lives_q - 3'(miss_cnt));
            end
            if (frame_tick && (lives_d == 3'd0)) begin
               state_d    = S_OVER;
               gameover_d = 1'b1;
            end else if (pause_tgl) begin
               state_d = S_PAUSE;
            end
         end

         S_PAUSE: begin
            if (pause_tgl) begin
               state_d = S_PLAY;
            end
         end

         S_OVER: begin
            if (start) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read port: samples lane contents as they stood before this edge
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_active_d = 1'b0;
      rd_ascii_d  = '0;
      rd_y_d      = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (rd_slot == SLOT_W'(i)) begin
            rd_active_d = active_q[i];
            rd_ascii_d  = ascii_q[i];
            rd_y_d      = y_q[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         active_q   <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            y_q[i]     <= '0;
            ascii_q[i] <= '0;
            speed_q[i] <= '0;
         end
         score_q     <= '0;
         lives_q     <= 3'(MAX_LIVES);
         gameover_q  <= 1'b0;
         rd_active_q <= 1'b0;
         rd_ascii_q  <= '0;
         rd_y_q      <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         y_q         <= y_d;
         ascii_q     <= ascii_d;
         speed_q     <= speed_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         gameover_q  <= gameover_d;
         rd_active_q <= rd_active_d;
         rd_ascii_q  <= rd_ascii_d;
         rd_y_q      <= rd_y_d;
      end
   end

   assign state     = state_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign gameover  = gameover_q;
   assign rd_active = rd_active_q;
   assign rd_ascii  = rd_ascii_q;
   assign rd_y      = rd_y_q;

endmodule

// File: tb/tb_fall_engine.sv
// -----------------------------------------------------------------------------
// tb_fall_engine
//   Directed test of fall_engine. The driver issues stimulus on posedge+1 and
//   pushes expected observations (tag + value) into a queue; the monitor pops
//   and compares them on the following falling edge.
// -----------------------------------------------------------------------------
module tb_fall_engine;

   localparam int SLOTS   = 8;
   localparam int SLOT_W  = 3;
   localparam int Y_W     = 10;
   localparam int SPEED_W = 3;
   localparam int SCORE_W = 8;

   localparam int T_STATE  = 0;
   localparam int T_SCORE  = 1;
   localparam int T_LIVES  = 2;
   localparam int T_GOVER  = 3;
   localparam int T_SREADY = 4;
   localparam int T_RACT   = 5;
   localparam int T_RASC   = 6;
   localparam int T_RY     = 7;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               pause_tgl;
   logic               frame_tick;
   logic               key_valid;
   logic [7:0]         key_ascii;
   logic               spawn_valid;
   logic [SLOT_W-1:0]  spawn_slot;
   logic [7:0]         spawn_ascii;
   logic [SPEED_W-1:0] spawn_speed;
   logic               spawn_ready;
   logic [SLOT_W-1:0]  rd_slot;
   logic               rd_active;
   logic [7:0]         rd_ascii;
   logic [Y_W-1:0]     rd_y;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score;
   logic [2:0]         lives;
   logic               gameover;

   fall_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pause_tgl   (pause_tgl),
      .frame_tick  (frame_tick),
      .key_valid   (key_valid),
      .key_ascii   (key_ascii),
      .spawn_valid (spawn_valid),
      .spawn_slot  (spawn_slot),
      .spawn_ascii (spawn_ascii),
      .spawn_speed (spawn_speed),
      .spawn_ready (spawn_ready),
      .rd_slot     (rd_slot),
      .rd_active   (rd_active),
      .rd_ascii    (rd_ascii),
      .rd_y        (rd_y),
      .state       (state),
      .score       (score),
      .lives       (lives),
      .gameover    (gameover)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [31:0] exp_q[$];
   int          tag_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   string       tag_name[8] = '{"state", "score", "lives", "gameover",
                                "spawn_ready", "rd_active", "rd_ascii", "rd_y"};

   function automatic logic [31:0] observe(input int tag);
      case (tag)
         T_STATE:  return 32'(state);
         T_SCORE:  return 32'(score);
         T_LIVES:  return 32'(lives);
         T_GOVER:  return 32'(gameover);
         T_SREADY: return 32'(spawn_ready);
         T_RACT:   return 32'(rd_active);
         T_RASC:   return 32'(rd_ascii);
         default:  return 32'(rd_y);
      endcase
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         automatic int          tag = tag_q.pop_front();
         automatic logic [31:0] exp = exp_q.pop_front();
         automatic logic [31:0] act = observe(tag);
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag_name[tag], act, exp, $time);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (all run at posedge+1)
   // ---------------------------------------------------------------------------
   task automatic expect_val(input int tag, input logic [31:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_tgl = 1'b1;
      cycle();
      pause_tgl = 1'b0;
   endtask

   task automatic press_key(input logic [7:0] k);
      key_valid = 1'b1;
      key_ascii = k;
      cycle();
      key_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      frame_tick = 1'b1;
      repeat (n) cycle();
      frame_tick = 1'b0;
   endtask

   task automatic spawn(input int s, input logic [7:0] a, input int spd);
      spawn_valid = 1'b1;
      spawn_slot  = SLOT_W'(s);
      spawn_ascii = a;
      spawn_speed = SPEED_W'(spd);
      expect_val(T_SREADY, 1);
      cycle();
      spawn_valid = 1'b0;
   endtask

   // Selects a lane, lets the read register capture it, then queues checks.
   task automatic read_slot(input int s, input logic act, input logic [7:0] a, input int y);
      rd_slot = SLOT_W'(s);
      cycle();
      expect_val(T_RACT, 32'(act));
      if (act) begin
         expect_val(T_RASC, 32'(a));
         expect_val(T_RY, 32'(y));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      pause_tgl   = 1'b0;
      frame_tick  = 1'b0;
      key_valid   = 1'b0;
      key_ascii   = 8'h00;
      spawn_valid = 1'b0;
      spawn_slot  = '0;
      spawn_ascii = 8'h00;
      spawn_speed = '0;
      rd_slot     = '0;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset values; a spawn offer in IDLE is refused.
      expect_val(T_STATE, 0);
      expect_val(T_SCORE, 0);
      expect_val(T_LIVES, 3);
      expect_val(T_GOVER, 0);
      expect_val(T_RACT, 0);
      expect_val(T_RASC, 0);
      expect_val(T_RY, 0);
      spawn_valid = 1'b1;
      spawn_slot  = 3'd0;
      expect_val(T_SREADY, 0);
      cycle();
      spawn_valid = 1'b0;

      pulse_start();
      expect_val(T_STATE, 1);
      expect_val(T_LIVES, 3);

      // Spawn lands in lane 2 and shows on the read port.
      spawn(2, 8'h41, 3);
      read_slot(2, 1'b1, 8'h41, 0);
      press_key(8'h41);
      read_slot(2, 1'b0, 8'h00, 0);
      expect_val(T_SCORE, 1);

      // Lane 5 'B' reaches y=200 while lane 0 'B' reaches y=100.
      spawn(5, 8'h42, 1);
      ticks(175);
      spawn(0, 8'h42, 4);
      ticks(25);
      read_slot(5, 1'b1, 8'h42, 200);
      read_slot(0, 1'b1, 8'h42, 100);
      press_key(8'h42);
      read_slot(5, 1'b0, 8'h00, 0);
      read_slot(0, 1'b1, 8'h42, 100);
      expect_val(T_SCORE, 2);
      press_key(8'h42);
      read_slot(0, 1'b0, 8'h00, 0);
      expect_val(T_SCORE, 3);
      press_key(8'h51);
      expect_val(T_SCORE, 3);

      // Pause freezes movement, keys and spawns.
      spawn(1, 8'h43, 2);
      ticks(10);
      read_slot(1, 1'b1, 8'h43, 20);
      pulse_pause();
      expect_val(T_STATE, 3);
      ticks(5);
      press_key(8'h43);
      spawn_valid = 1'b1;
      spawn_slot  = 3'd3;
      spawn_ascii = 8'h52;
      spawn_speed = 3'd1;
      expect_val(T_SREADY, 0);
      cycle();
      spawn_valid = 1'b0;
      read_slot(1, 1'b1, 8'h43, 20);
      read_slot(3, 1'b0, 8'h00, 0);
      expect_val(T_SCORE, 3);
      pulse_pause();
      expect_val(T_STATE, 1);
      press_key(8'h43);
      expect_val(T_SCORE, 4);

      // Key and the tick that would miss the lane arrive together: key wins.
      spawn(4, 8'h44, 2);
      ticks(239);
      read_slot(4, 1'b1, 8'h44, 478);
      key_valid  = 1'b1;
      key_ascii  = 8'h44;
      frame_tick = 1'b1;
      cycle();
      key_valid  = 1'b0;
      frame_tick = 1'b0;
      expect_val(T_LIVES, 3);
      expect_val(T_SCORE, 5);
      read_slot(4, 1'b0, 8'h00, 0);

      // Two lanes cross the bound on the same tick.
      spawn(6, 8'h58, 5);
      spawn(7, 8'h59, 5);
      ticks(95);
      read_slot(6, 1'b1, 8'h58, 475);
      ticks(1);
      expect_val(T_LIVES, 1);
      expect_val(T_STATE, 1);
      expect_val(T_GOVER, 0);
      read_slot(6, 1'b0, 8'h00, 0);
      read_slot(7, 1'b0, 8'h00, 0);

      // Last life: 477 + 3 = 480 lands exactly on the bound.
      spawn(2, 8'h5A, 3);
      ticks(159);
      read_slot(2, 1'b1, 8'h5A, 477);
      expect_val(T_LIVES, 1);
      ticks(1);
      expect_val(T_STATE, 2);
      expect_val(T_LIVES, 0);
      expect_val(T_GOVER, 1);
      cycle();
      expect_val(T_GOVER, 0);
      expect_val(T_STATE, 2);

      // OVER -> IDLE -> PLAY with fresh counters.
      pulse_start();
      expect_val(T_STATE, 0);
      pulse_start();
      expect_val(T_STATE, 1);
      expect_val(T_LIVES, 3);
      expect_val(T_SCORE, 0);

      // Asynchronous reset mid-game: checked on the falling edge before any
      // rising edge has passed.
      spawn(3, 8'h52, 1);
      ticks(3);
      press_key(8'h52);
      expect_val(T_SCORE, 1);
      spawn(3, 8'h53, 1);
      cycle();
      rst_n = 1'b0;
      expect_val(T_STATE, 0);
      expect_val(T_SCORE, 0);
      expect_val(T_LIVES, 3);
      expect_val(T_RACT, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      pulse_start();
      read_slot(3, 1'b0, 8'h00, 0);

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got time %0t, expected completion", $time);
      $fatal(1, "time limit");
   end

endmodule
